// File: rtl/parity_frame_accumulator.sv
// parity_frame_accumulator: groups a valid/ready bit stream into FRAME_LEN-bit frames
// and presents each frame's parity and ones-count on a held valid/ready output.
module parity_frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4,
    parameter int DONE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              parity_out,
    output logic [CNT_W-1:0]  ones_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_abort,
    output logic [DONE_W-1:0] frames_done
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, acc_ones_q, acc_ones_d, ones_q, ones_d;
    logic               acc_par_q, acc_par_d, par_q, par_d, abort_q, abort_d;
    logic [DONE_W-1:0]  done_q, done_d;

    assign in_ready    = state_q != HOLD;
    assign out_valid   = state_q == HOLD;
    assign parity_out  = par_q;
    assign ones_count  = ones_q;
    assign frame_abort = abort_q;
    assign frames_done = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_par_d  = acc_par_q;
        acc_ones_d = acc_ones_q;
        par_d      = par_q;
        ones_d     = ones_q;
        abort_d    = 1'b0;
        done_d     = done_q;
        if (state_q == HOLD) begin
            if (out_ready) begin
                state_d = IDLE;
                done_d  = done_q + DONE_W'(1);
            end
        end else if (in_valid) begin
            if (in_start) begin
                cnt_d      = CNT_W'(1);
                acc_par_d  = in_bit;
                acc_ones_d = CNT_W'(in_bit);
                abort_d    = state_q == ACCUM;
            end else if (state_q == ACCUM) begin
                cnt_d      = cnt_q + CNT_W'(1);
                acc_par_d  = acc_par_q ^ in_bit;
                acc_ones_d = acc_ones_q + CNT_W'(in_bit);
            end
            // Non-start bits in IDLE fall through here untouched and are dropped.
            if (in_start || state_q == ACCUM) begin
                state_d = (cnt_d == CNT_W'(FRAME_LEN)) ? HOLD : ACCUM;
                if (cnt_d == CNT_W'(FRAME_LEN)) begin
                    par_d  = acc_par_d;
                    ones_d = acc_ones_d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_par_q  <= 1'b0;
            acc_ones_q <= '0;
            par_q      <= 1'b0;
            ones_q     <= '0;
            abort_q    <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_par_q  <= acc_par_d;
            acc_ones_q <= acc_ones_d;
            par_q      <= par_d;
            ones_q     <= ones_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_parity_frame_accumulator.sv
// tb_parity_frame_accumulator: directed and random checks of the frame accumulator
// against a queue-based frame model, plus a FRAME_LEN=1 instance.
module tb_parity_frame_accumulator;
    logic clk = 1'b0, rst = 1'b1;
    logic in_bit = 1'b0, in_start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, parity_out, out_valid, frame_abort;
    logic [3:0] ones_count;
    logic [7:0] frames_done;
    logic b2 = 1'b0, s2 = 1'b0, v2 = 1'b0, r2 = 1'b0;
    logic rdy2, par2, ov2, ab2;
    logic [3:0] ones2;
    logic [1:0] fd2;
    int errs = 0, checks = 0;

    bit   m_hold, m_in, m_par, m_abort;
    int   m_ones, m_done;
    int   q[$];

    always #5 clk = ~clk;

    parity_frame_accumulator #(.FRAME_LEN(8), .CNT_W(4), .DONE_W(8)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_start(in_start), .in_valid(in_valid),
        .in_ready(in_ready), .parity_out(parity_out), .ones_count(ones_count),
        .out_valid(out_valid), .out_ready(out_ready), .frame_abort(frame_abort),
        .frames_done(frames_done));

    parity_frame_accumulator #(.FRAME_LEN(1), .CNT_W(4), .DONE_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_bit(b2), .in_start(s2), .in_valid(v2),
        .in_ready(rdy2), .parity_out(par2), .ones_count(ones2),
        .out_valid(ov2), .out_ready(r2), .frame_abort(ab2), .frames_done(fd2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_in = 0; m_par = 0; m_abort = 0; m_ones = 0; m_done = 0; q.delete();
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, m_hold);
        chk("in_ready", in_ready, !m_hold);
        chk("parity_out", parity_out, m_par);
        chk("ones_count", ones_count, m_ones);
        chk("frames_done", frames_done, m_done);
        chk("frame_abort", frame_abort, m_abort);
    endtask

    task automatic step(input logic v, input logic s, input logic b, input logic r);
        int sum;
        in_valid = v; in_start = s; in_bit = b; out_ready = r;
        @(posedge clk);
        m_abort = 0;
        if (m_hold) begin
            if (r) begin m_hold = 0; m_done = (m_done + 1) % 256; end
        end else if (v) begin
            if (s) begin
                m_abort = m_in;
                q.delete(); q.push_back(int'(b)); m_in = 1;
            end else if (m_in) q.push_back(int'(b));
            if (m_in && q.size() == 8) begin
                sum = 0;
                foreach (q[i]) sum += q[i];
                m_par = sum[0]; m_ones = sum; m_hold = 1; m_in = 0; q.delete();
            end
        end
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [7:0] bits, input logic r);
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, bits[7-i], r);
    endtask

    task automatic async_reset(input string tag);
        in_valid = 0; in_start = 0; out_ready = 0;
        #2 rst = 1'b1;
        #1;
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_par"}, parity_out, 0);
        chk({tag, "_ones"}, ones_count, 0);
        chk({tag, "_done"}, frames_done, 0);
        chk({tag, "_abort"}, frame_abort, 0);
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_ov", out_valid, 0);
        chk("rst_done", frames_done, 0);
        chk("rst_ones", ones_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();
        // basic frame with immediate consumption
        send_frame(8'b1011_0001, 1'b1);
        chk("t1_par", parity_out, 0);
        chk("t1_ones", ones_count, 4);
        step(0, 0, 0, 1);
        chk("t1_done", frames_done, 1);
        // stalled consumer, extra beats must be refused
        send_frame(8'b1011_0001, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
        chk("stall_ready", in_ready, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("stall_done", frames_done, 2);
        // abort after 3 bits, then 8 ones
        step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        chk("abort_pulse", frame_abort, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 1, 0);
        chk("abort_par", parity_out, 0);
        chk("abort_ones", ones_count, 8);
        step(0, 0, 0, 1);
        // reset, then non-start beats in IDLE
        async_reset("rst_idle");
        for (int i = 0; i < 10; i++) step(1, 0, i[0], 1);
        chk("idle_done", frames_done, 0);
        // reset mid-frame and during HOLD
        for (int i = 0; i < 5; i++) step(1, i == 0, 1, 1);
        async_reset("rst_mid");
        send_frame(8'b1110_0000, 1'b0);
        chk("hold_ov", out_valid, 1);
        async_reset("rst_hold");
        send_frame(8'b0110_1011, 1'b1);
        chk("post_ones", ones_count, 5);
        chk("post_par", parity_out, 1);
        step(0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(3) != 0, $urandom_range(9) == 0, 1'($urandom), $urandom_range(2) != 0);
        // FRAME_LEN=1 instance
        async_reset("rst_fl1");
        for (int i = 0; i < 5; i++) begin
            logic bb;
            bb = 1'($urandom);
            v2 = 1; s2 = 1; b2 = bb; r2 = 1;
            @(posedge clk); #1;
            chk("fl1_ov", ov2, 1);
            chk("fl1_par", par2, bb);
            chk("fl1_ones", ones2, bb);
            chk("fl1_rdy", rdy2, 0);
            v2 = 0; s2 = 0;
            @(posedge clk); #1;
            chk("fl1_ov_low", ov2, 0);
            chk("fl1_done", fd2, (i + 1) % 4);
            chk("fl1_hold_par", par2, bb);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
